// File: rtl/tilt_movement_pkg.sv
// Shared state encodings and default tuning constants for the tilt movement filter.
package tilt_movement_pkg;

  typedef enum logic [1:0] {
    LAT_NEUTRAL,
    LAT_LEFT,
    LAT_RIGHT
  } lateral_state_t;

  typedef enum logic [1:0] {
    JMP_READY,
    JMP_HOLD,
    JMP_RELEASE,
    JMP_COOLDOWN
  } jump_state_t;

  localparam int DEF_DATA_W        = 16;
  localparam int DEF_TILT_ON       = 100;
  localparam int DEF_TILT_OFF      = 60;
  localparam int DEF_JUMP_ON       = 200;
  localparam int DEF_JUMP_OFF      = 120;
  localparam int DEF_DEBOUNCE_N    = 3;
  localparam int DEF_JUMP_HOLD     = 8;
  localparam int DEF_JUMP_COOLDOWN = 16;

  // Bits needed to hold values 0..maxCount, never narrower than one bit.
  function automatic int cntWidth(input int maxCount);
    return (maxCount < 1) ? 1 : $clog2(maxCount + 1);
  endfunction

endpackage

// File: rtl/sample_debouncer.sv
// Counts consecutive valid samples meeting a condition; strobes done on the Nth one.
module sample_debouncer
  import tilt_movement_pkg::*;
#(
  parameter int DEBOUNCE_N = DEF_DEBOUNCE_N
) (
  input  logic clk_i,
  input  logic reset_i,
  input  logic sample_valid_i,
  input  logic cond_i,
  input  logic clear_i,
  output logic done_o
);

  localparam int            CW      = cntWidth(DEBOUNCE_N);
  localparam logic [CW-1:0] LastCnt = CW'(DEBOUNCE_N - 1);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;
  logic [CW-1:0] base;

  // A clear arriving together with a sample restarts the run at that sample.
  assign base   = clear_i ? '0 : cnt_q;
  assign done_o = sample_valid_i && cond_i && (base == LastCnt);

  always_comb begin
    cnt_d = cnt_q;
    if (sample_valid_i) begin
      if (!cond_i || done_o) begin
        cnt_d = '0;
      end else begin
        cnt_d = base + CW'(1);
      end
    end else if (clear_i) begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/tilt_movement_filter.sv
// Turns raw lateral/vertical acceleration samples into debounced left/right
// tilt flags with hysteresis and a held, rate-limited jump indication.
module tilt_movement_filter
  import tilt_movement_pkg::*;
#(
  parameter int DATA_W        = DEF_DATA_W,
  parameter int TILT_ON       = DEF_TILT_ON,
  parameter int TILT_OFF      = DEF_TILT_OFF,
  parameter int JUMP_ON       = DEF_JUMP_ON,
  parameter int JUMP_OFF      = DEF_JUMP_OFF,
  parameter int DEBOUNCE_N    = DEF_DEBOUNCE_N,
  parameter int JUMP_HOLD     = DEF_JUMP_HOLD,
  parameter int JUMP_COOLDOWN = DEF_JUMP_COOLDOWN
) (
  input  logic                     clk_i,
  input  logic                     reset_i,
  input  logic                     sample_valid_i,
  input  logic signed [DATA_W-1:0] data_x_i,
  input  logic signed [DATA_W-1:0] data_y_i,
  output logic                     left_o,
  output logic                     right_o,
  output logic                     jump_o,
  output logic                     jump_pulse_o
);

  // One extra bit keeps -TILT_ON and the most negative sample representable.
  localparam logic signed [DATA_W:0] TiltOnPos  = (DATA_W+1)'(TILT_ON);
  localparam logic signed [DATA_W:0] TiltOnNeg  = -TiltOnPos;
  localparam logic signed [DATA_W:0] TiltOffPos = (DATA_W+1)'(TILT_OFF);
  localparam logic signed [DATA_W:0] TiltOffNeg = -TiltOffPos;
  localparam logic signed [DATA_W:0] JumpOnS    = (DATA_W+1)'(JUMP_ON);
  localparam logic signed [DATA_W:0] JumpOffS   = (DATA_W+1)'(JUMP_OFF);

  localparam int            JW       = cntWidth((JUMP_HOLD > JUMP_COOLDOWN) ? JUMP_HOLD : JUMP_COOLDOWN);
  localparam logic [JW-1:0] HoldLast = JW'(JUMP_HOLD);
  localparam logic [JW-1:0] CoolLast = JW'((JUMP_COOLDOWN > 0) ? JUMP_COOLDOWN - 1 : 0);

  logic signed [DATA_W:0] xExt;
  logic signed [DATA_W:0] yExt;
  logic overLeft, overRight, backFromLeft, backFromRight;
  logic jumpAbove, jumpBelow;

  assign xExt          = {data_x_i[DATA_W-1], data_x_i};
  assign yExt          = {data_y_i[DATA_W-1], data_y_i};
  assign overLeft      = xExt > TiltOnPos;
  assign overRight     = xExt < TiltOnNeg;
  assign backFromLeft  = xExt <= TiltOffPos;
  assign backFromRight = xExt >= TiltOffNeg;
  assign jumpAbove     = yExt > JumpOnS;
  assign jumpBelow     = yExt <= JumpOffS;

  lateral_state_t latState_q;
  logic           left_q, right_q, pendRight_q;
  logic           latCond, latClear, latDone;

  always_comb begin
    latCond = 1'b0;
    case (latState_q)
      LAT_NEUTRAL: latCond = overLeft | overRight;
      LAT_LEFT:    latCond = backFromLeft;
      LAT_RIGHT:   latCond = backFromRight;
      default:     latCond = 1'b0;
    endcase
  end

  // In NEUTRAL a run toward the opposite side must start counting afresh.
  assign latClear = sample_valid_i && (latState_q == LAT_NEUTRAL) &&
                    (overLeft | overRight) && (overRight != pendRight_q);

  sample_debouncer #(
    .DEBOUNCE_N(DEBOUNCE_N)
  ) u_lat_debouncer (
    .clk_i         (clk_i),
    .reset_i       (reset_i),
    .sample_valid_i(sample_valid_i),
    .cond_i        (latCond),
    .clear_i       (latClear),
    .done_o        (latDone)
  );

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      latState_q  <= LAT_NEUTRAL;
      left_q      <= 1'b0;
      right_q     <= 1'b0;
      pendRight_q <= 1'b0;
    end else if (sample_valid_i) begin
      if ((latState_q == LAT_NEUTRAL) && (overLeft | overRight)) begin
        pendRight_q <= overRight;
      end
      if (latDone) begin
        case (latState_q)
          LAT_NEUTRAL: begin
            if (overRight) begin
              latState_q <= LAT_RIGHT;
              right_q    <= 1'b1;
            end else begin
              latState_q <= LAT_LEFT;
              left_q     <= 1'b1;
            end
          end
          LAT_LEFT: begin
            latState_q <= LAT_NEUTRAL;
            left_q     <= 1'b0;
          end
          LAT_RIGHT: begin
            latState_q <= LAT_NEUTRAL;
            right_q    <= 1'b0;
          end
          default: begin
            latState_q <= LAT_NEUTRAL;
            left_q     <= 1'b0;
            right_q    <= 1'b0;
          end
        endcase
      end
    end
  end

  jump_state_t   jumpState_q;
  logic [JW-1:0] jumpCnt_q;
  logic          jump_q, pulse_q;

  // The pulse is a strobe, so it drops on the following clock even without a sample.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      jumpState_q <= JMP_READY;
      jumpCnt_q   <= '0;
      jump_q      <= 1'b0;
      pulse_q     <= 1'b0;
    end else begin
      pulse_q <= 1'b0;
      if (sample_valid_i) begin
        case (jumpState_q)
          JMP_READY: begin
            if (jumpAbove) begin
              jumpState_q <= JMP_HOLD;
              jumpCnt_q   <= JW'(1);
              jump_q      <= 1'b1;
              pulse_q     <= 1'b1;
            end
          end
          JMP_HOLD: begin
            if (jumpCnt_q == HoldLast) begin
              jumpState_q <= JMP_RELEASE;
              jumpCnt_q   <= '0;
              jump_q      <= 1'b0;
            end else begin
              jumpCnt_q <= jumpCnt_q + JW'(1);
            end
          end
          JMP_RELEASE: begin
            if (jumpBelow) begin
              jumpCnt_q   <= '0;
              jumpState_q <= (JUMP_COOLDOWN == 0) ? JMP_READY : JMP_COOLDOWN;
            end
          end
          JMP_COOLDOWN: begin
            if (jumpCnt_q == CoolLast) begin
              jumpState_q <= JMP_READY;
              jumpCnt_q   <= '0;
            end else begin
              jumpCnt_q <= jumpCnt_q + JW'(1);
            end
          end
          default: begin
            jumpState_q <= JMP_READY;
            jumpCnt_q   <= '0;
            jump_q      <= 1'b0;
          end
        endcase
      end
    end
  end

  assign left_o       = left_q;
  assign right_o      = right_q;
  assign jump_o       = jump_q;
  assign jump_pulse_o = pulse_q;

endmodule

// File: tb/tb_tilt_movement_filter.sv
// Self-checking bench for tilt_movement_filter: fixed vectors, directed corner
// sequences and randomized traffic against a sample-history reference model.
module tb_tilt_movement_filter;

  localparam int DW   = 16;
  localparam int TON  = 100;
  localparam int TOFF = 60;
  localparam int JON  = 200;
  localparam int JOFF = 120;
  localparam int DBN  = 3;
  localparam int JH   = 8;
  localparam int JC   = 16;

  logic                 clk;
  logic                 reset;
  logic                 sampleValid;
  logic signed [DW-1:0] dataX;
  logic signed [DW-1:0] dataY;
  logic                 left, right, jump, jumpPulse;

  int nCompared   = 0;
  int nMismatched = 0;

  tilt_movement_filter #(
    .DATA_W(DW), .TILT_ON(TON), .TILT_OFF(TOFF), .JUMP_ON(JON), .JUMP_OFF(JOFF),
    .DEBOUNCE_N(DBN), .JUMP_HOLD(JH), .JUMP_COOLDOWN(JC)
  ) dut (
    .clk_i         (clk),
    .reset_i       (reset),
    .sample_valid_i(sampleValid),
    .data_x_i      (dataX),
    .data_y_i      (dataY),
    .left_o        (left),
    .right_o       (right),
    .jump_o        (jump),
    .jump_pulse_o  (jumpPulse)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: lateral decisions look back over the samples seen since the
  // last lateral change; jump timing is derived from sample indices.
  int      xHist[$];
  int      mLat;
  int      mJump;
  longint  sampleIdx;
  longint  trigIdx;
  longint  relIdx;
  bit      mPulse;

  function automatic bit lastNAll(input int kind);
    if (xHist.size() < DBN) return 1'b0;
    for (int i = xHist.size() - DBN; i < xHist.size(); i++) begin
      case (kind)
        0: if (!(xHist[i] > TON))    return 1'b0;
        1: if (!(xHist[i] < -TON))   return 1'b0;
        2: if (!(xHist[i] <= TOFF))  return 1'b0;
        default: if (!(xHist[i] >= -TOFF)) return 1'b0;
      endcase
    end
    return 1'b1;
  endfunction

  task automatic modelClock(input logic rst, input logic v, input int x, input int y);
    mPulse = 1'b0;
    if (rst) begin
      mLat  = 0;
      mJump = 0;
      xHist.delete();
    end else if (v) begin
      sampleIdx++;
      xHist.push_back(x);
      if (mLat == 0 && lastNAll(0)) begin mLat = 1; xHist.delete(); end
      else if (mLat == 0 && lastNAll(1)) begin mLat = 2; xHist.delete(); end
      else if (mLat == 1 && lastNAll(2)) begin mLat = 0; xHist.delete(); end
      else if (mLat == 2 && lastNAll(3)) begin mLat = 0; xHist.delete(); end
      case (mJump)
        0: if (y > JON) begin mJump = 1; trigIdx = sampleIdx; mPulse = 1'b1; end
        1: if (sampleIdx - trigIdx == JH) mJump = 2;
        2: if (y <= JOFF) begin mJump = (JC == 0) ? 0 : 3; relIdx = sampleIdx; end
        default: if (sampleIdx - relIdx == JC) mJump = 0;
      endcase
    end
  endtask

  function automatic logic [3:0] modelExp();
    return {mLat == 1, mLat == 2, mJump == 1, mPulse};
  endfunction

  task automatic applyStimulus(input logic rst, input logic v, input int x, input int y);
    reset       = rst;
    sampleValid = v;
    dataX       = DW'(x);
    dataY       = DW'(y);
    @(posedge clk);
    modelClock(rst, v, x, y);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [3:0] exp);
    logic [3:0] got;
    got = {left, right, jump, jumpPulse};
    nCompared++;
    if (got !== exp) begin
      nMismatched++;
      $display("[TB] FAIL %s: got {L,R,J,P}=%b expected %b", name, got, exp);
    end
  endtask

  task automatic stepCheck(input string name, input logic rst, input logic v, input int x, input int y);
    applyStimulus(rst, v, x, y);
    checkOutput(name, modelExp());
  endtask

  function automatic int pickVal(input int onT, input int offT);
    case ($urandom_range(0, 6))
      0:       return int'($urandom_range(0, 65535)) - 32768;
      1:       return onT + int'($urandom_range(0, 4)) - 2;
      2:       return -onT + int'($urandom_range(0, 4)) - 2;
      3:       return offT + int'($urandom_range(0, 4)) - 2;
      4:       return -offT + int'($urandom_range(0, 4)) - 2;
      5:       return ($urandom_range(0, 1) != 0) ? 32767 : -32768;
      default: return 0;
    endcase
  endfunction

  typedef struct {
    logic       rst;
    logic       v;
    int         x;
    int         y;
    logic [3:0] exp;
  } vec_t;

  vec_t vecs[$];

  initial begin
    int rx, ry;
    mLat = 0; mJump = 0; sampleIdx = 0; trigIdx = 0; relIdx = 0; mPulse = 1'b0;
    reset = 1'b1; sampleValid = 1'b0; dataX = '0; dataY = '0;

    vecs.push_back('{1'b1, 1'b0,    0,   0, 4'b0000});
    vecs.push_back('{1'b0, 1'b1,  150,   0, 4'b0000});
    vecs.push_back('{1'b0, 1'b1,  150,   0, 4'b0000});
    vecs.push_back('{1'b0, 1'b0,  150,   0, 4'b0000});
    vecs.push_back('{1'b0, 1'b1,  150,   0, 4'b1000});
    vecs.push_back('{1'b0, 1'b1,   80,   0, 4'b1000});
    vecs.push_back('{1'b0, 1'b1,   60,   0, 4'b1000});
    vecs.push_back('{1'b0, 1'b1,   60,   0, 4'b1000});
    vecs.push_back('{1'b0, 1'b1,   60,   0, 4'b0000});
    vecs.push_back('{1'b0, 1'b1,  150,   0, 4'b0000});
    vecs.push_back('{1'b0, 1'b1,  150,   0, 4'b0000});
    vecs.push_back('{1'b0, 1'b1,   50,   0, 4'b0000});
    vecs.push_back('{1'b0, 1'b1,  150,   0, 4'b0000});
    vecs.push_back('{1'b0, 1'b1,  150,   0, 4'b0000});
    vecs.push_back('{1'b0, 1'b1,  150,   0, 4'b1000});
    vecs.push_back('{1'b1, 1'b1, -150,   0, 4'b0000});
    vecs.push_back('{1'b0, 1'b1,    0, 250, 4'b0011});
    vecs.push_back('{1'b0, 1'b0,    0, 250, 4'b0010});
    vecs.push_back('{1'b1, 1'b1,    0, 250, 4'b0000});
    vecs.push_back('{1'b0, 1'b1,    0, 200, 4'b0000});
    vecs.push_back('{1'b0, 1'b1,    0, 250, 4'b0011});
    vecs.push_back('{1'b1, 1'b0,    0,   0, 4'b0000});

    applyStimulus(1'b1, 1'b0, 0, 0);
    foreach (vecs[i]) begin
      applyStimulus(vecs[i].rst, vecs[i].v, vecs[i].x, vecs[i].y);
      checkOutput($sformatf("vec%0d", i), vecs[i].exp);
    end

    // Left straight to right must pass through neutral with two full debounces.
    stepCheck("swapReset", 1'b1, 1'b0, 0, 0);
    for (int i = 0; i < 3; i++) stepCheck("swapLeft", 1'b0, 1'b1, 150, 0);
    checkOutput("swapLeftOn", 4'b1000);
    for (int i = 0; i < 3; i++) stepCheck("swapNeutral", 1'b0, 1'b1, -150, 0);
    checkOutput("swapNeutralOn", 4'b0000);
    for (int i = 0; i < 3; i++) stepCheck("swapRight", 1'b0, 1'b1, -150, 0);
    checkOutput("swapRightOn", 4'b0100);

    stepCheck("extReset", 1'b1, 1'b0, 0, 0);
    for (int i = 0; i < 3; i++) stepCheck("extNeg", 1'b0, 1'b1, -32768, 0);
    checkOutput("extNegRight", 4'b0100);
    for (int i = 0; i < 3; i++) stepCheck("extExit", 1'b0, 1'b1, -60, 0);
    checkOutput("extExitEdge", 4'b0000);
    for (int i = 0; i < 3; i++) stepCheck("extPos", 1'b0, 1'b1, 32767, 0);
    checkOutput("extPosLeft", 4'b1000);

    // Held trigger level must not retrigger until release plus full cooldown.
    stepCheck("jmpReset", 1'b1, 1'b0, 0, 0);
    stepCheck("jmpTrig", 1'b0, 1'b1, 0, 250);
    checkOutput("jmpTrigPulse", 4'b0011);
    for (int i = 0; i < JH - 1; i++) stepCheck("jmpHold", 1'b0, 1'b1, 0, 250);
    checkOutput("jmpHoldLast", 4'b0010);
    stepCheck("jmpEnd", 1'b0, 1'b1, 0, 250);
    checkOutput("jmpEndLow", 4'b0000);
    for (int i = 0; i < 20; i++) stepCheck("jmpNoRetrig", 1'b0, 1'b1, 0, 250);
    stepCheck("jmpRelease", 1'b0, 1'b1, 0, 120);
    for (int i = 0; i < JC; i++) stepCheck("jmpCool", 1'b0, 1'b1, 0, 250);
    checkOutput("jmpCoolEnd", 4'b0000);
    stepCheck("jmpRetrig", 1'b0, 1'b1, 0, 250);
    checkOutput("jmpRetrigPulse", 4'b0011);

    stepCheck("rndReset", 1'b1, 1'b0, 0, 0);
    rx = 0; ry = 0;
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 9) < 3) rx = pickVal(TON, TOFF);
      if ($urandom_range(0, 9) < 3) ry = pickVal(JON, JOFF);
      stepCheck("random", $urandom_range(0, 299) == 0, $urandom_range(0, 9) < 7, rx, ry);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule

// File: doc/tilt_movement_filter.md
TILT_MOVEMENT_FILTER -- requirements
Module: tilt_movement_filter

Interface
REQ-001 SHALL have parameter DATA_W, default 16, sample width in bits, two's complement.
REQ-002 SHALL have parameter TILT_ON, default 100, lateral entry threshold; legal range 0 < TILT_OFF < TILT_ON < 2**(DATA_W-1).
REQ-003 SHALL have parameter TILT_OFF, default 60, lateral exit threshold (hysteresis).
REQ-004 SHALL have parameter JUMP_ON, default 200, jump trigger threshold; legal range 0 < JUMP_OFF < JUMP_ON < 2**(DATA_W-1).
REQ-005 SHALL have parameter JUMP_OFF, default 120, jump release threshold.
REQ-006 SHALL have parameter DEBOUNCE_N, default 3, consecutive samples needed for any lateral transition; must be >= 1.
REQ-007 SHALL have parameter JUMP_HOLD, default 8, samples jump stays high; must be >= 1.
REQ-008 SHALL have parameter JUMP_COOLDOWN, default 16, samples of lockout after release; 0 is legal.
REQ-009 clk  input  1  single clock; all logic on its rising edge.
REQ-010 reset  input  1  synchronous, active-high reset.
REQ-011 sample_valid  input  1  one-cycle strobe; data_x and data_y are valid this cycle.
REQ-012 data_x  input  DATA_W  signed lateral acceleration.
REQ-013 data_y  input  DATA_W  signed vertical acceleration.
REQ-014 left  output  1  registered; lateral state is LEFT.
REQ-015 right  output  1  registered; lateral state is RIGHT.
REQ-016 jump  output  1  registered; jump state is HOLD.
REQ-017 jump_pulse  output  1  registered one-cycle strobe at jump start.

Function
REQ-018 SHALL evaluate thresholds only in cycles with sample_valid=1; all states, counters and outputs hold otherwise.
REQ-019 SHALL compare signed values, with constants sign-extended to DATA_W+1 bits so that -TILT_ON and data = -2**(DATA_W-1) never overflow.
REQ-020 Lateral FSM SHALL have states NEUTRAL, LEFT, RIGHT.
REQ-021 NEUTRAL->LEFT SHALL occur on the DEBOUNCE_N-th consecutive sample with data_x > TILT_ON; NEUTRAL->RIGHT on the DEBOUNCE_N-th consecutive sample with data_x < -TILT_ON.
REQ-022 LEFT->NEUTRAL SHALL occur on the DEBOUNCE_N-th consecutive sample with data_x <= TILT_OFF; RIGHT->NEUTRAL on the DEBOUNCE_N-th consecutive sample with data_x >= -TILT_OFF.
REQ-023 Any sample failing the pending condition SHALL clear the debounce counter to 0; the counter SHALL also clear on every state change.
REQ-024 LEFT<->RIGHT SHALL never be direct; the path passes through NEUTRAL and a fresh debounce.
REQ-025 left and right SHALL never be 1 simultaneously.
REQ-026 Jump FSM SHALL have states READY, HOLD, RELEASE, COOLDOWN.
REQ-027 READY->HOLD SHALL occur on one sample with data_y > JUMP_ON; jump_pulse=1 for exactly the next clock only.
REQ-028 HOLD->RELEASE SHALL occur after JUMP_HOLD samples counted in HOLD, including the trigger sample.
REQ-029 RELEASE->COOLDOWN SHALL occur on the first sample with data_y <= JUMP_OFF; RELEASE->READY directly when JUMP_COOLDOWN=0.
REQ-030 COOLDOWN->READY SHALL occur after JUMP_COOLDOWN samples; retriggering is impossible outside READY.
REQ-031 Lateral and jump FSMs SHALL be independent; a single sample may transition both.
REQ-032 Latency SHALL be exactly one clock from the accepting sample_valid edge to the output change.

Reset
REQ-033 With reset=1 at a clock edge: lateral state NEUTRAL, jump state READY, all counters 0, left=right=jump=jump_pulse=0 from the next cycle.
REQ-034 Reset SHALL take priority over sample_valid in the same cycle; the sample is discarded.
REQ-035 Reset mid-HOLD or mid-debounce SHALL abort it with no jump_pulse and no residual count.

Structure
REQ-036 Package tilt_movement_pkg SHALL hold lateral_state_t, jump_state_t enums and the default threshold/count constants.
REQ-037 Sub-module sample_debouncer (condition in, sample_valid, clear, DEBOUNCE_N -> done strobe) SHALL be instantiated once for the lateral FSM.
REQ-038 Counter widths SHALL be $clog2 of (max count + 1), minimum 1 bit.

Verification (defaults)
REQ-039 data_x=150 on 3 samples -> left=1 one clock after 3rd; 2 samples then data_x=50 -> left stays 0.
REQ-040 In LEFT: data_x=80 on 10 samples -> left held (hysteresis); data_x=60 on 3 samples -> left=0.
REQ-041 In LEFT: data_x=-150 on 3 samples -> NEUTRAL; 3 more -> right=1; left/right never both 1.
REQ-042 data_y=250 one sample -> jump_pulse 1 clock, jump high 8 samples; y held 250 -> no retrigger until y<=120 then 16 samples.
REQ-043 data_x=-32768 on 3 samples -> right=1; data_x=32767 in NEUTRAL on 3 samples -> left=1.
REQ-044 Reset asserted during HOLD with sample_valid=1 -> all outputs 0 next clock, jump state READY.
